// File: rtl/cv32e40p_pkg.sv
// Shared CV32E40P types: sleep controller state encoding and sizing helper.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    SLP_OFF   = 2'd0,
    SLP_RUN   = 2'd1,
    SLP_DRAIN = 2'd2,
    SLP_SLEEP = 2'd3
  } sleep_state_e;

  // Idle counter width; a zero-cycle hysteresis still needs one bit.
  function automatic int unsigned idle_cnt_width(int unsigned idle_cycles);
    return (idle_cycles == 0) ? 1 : $clog2(idle_cycles + 1);
  endfunction

endpackage

// File: rtl/cv32e40p_clock_gate.sv
// Latch-based clock gate: enable is captured while the clock is low so the gated clock never glitches.
module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_latched;

  always_latch begin
    if (!clk_i) en_latched <= en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/cv32e40p_sleep_ctrl_mc.sv
// Multi-domain sleep controller: per-domain gated clocks, WFI sleep with idle hysteresis, p.elw sleep.
module cv32e40p_sleep_ctrl_mc
  import cv32e40p_pkg::*;
#(
  parameter int unsigned                NUM_DOMAINS    = 2,
  parameter int unsigned                IDLE_CYCLES    = 4,
  parameter logic [NUM_DOMAINS-1:0]     AUTO_GATE_MASK = '0,
  parameter int unsigned                PULP_CLUSTER   = 0
) (
  input  logic                   clk_ungated_i,
  input  logic                   rst,
  input  logic                   scan_cg_en_i,
  output logic [NUM_DOMAINS-1:0] clk_gated_o,
  output logic                   core_sleep_o,
  input  logic                   fetch_enable_i,
  output logic                   fetch_enable_o,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  input  logic                   wake_from_sleep_i,
  input  logic                   pulp_clock_en_i,
  input  logic                   p_elw_start_i,
  input  logic                   p_elw_finish_i,
  input  logic                   debug_p_elw_no_sleep_i,
  output logic [1:0]             sleep_state_o
);

  localparam int unsigned CNT_W = idle_cnt_width(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (IDLE_CYCLES == 0) ? '0 : CNT_W'(IDLE_CYCLES - 1);

  sleep_state_e            state, state_n;
  logic [CNT_W-1:0]        idle_cnt, idle_cnt_n;
  logic [NUM_DOMAINS-1:0]  busy_q;
  logic                    fetch_enable_q;
  logic                    any_busy;
  logic [NUM_DOMAINS-1:0]  run_en, en, gate_en;
  logic                    core_sleep;

  always_ff @(posedge clk_ungated_i or posedge rst) begin
    if (rst) begin
      state          <= SLP_OFF;
      idle_cnt       <= '0;
      busy_q         <= '0;
      fetch_enable_q <= 1'b0;
    end else begin
      state          <= state_n;
      idle_cnt       <= idle_cnt_n;
      busy_q         <= busy_i;
      fetch_enable_q <= fetch_enable_q | fetch_enable_i;
    end
  end

  assign any_busy = |busy_q;
  assign run_en   = ~AUTO_GATE_MASK | busy_q | {NUM_DOMAINS{wake_from_sleep_i}};

  // SLP_SLEEP doubles as the p.elw state when the cluster option is selected.
  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    en         = '0;
    core_sleep = 1'b0;
    case (state)
      SLP_OFF: begin
        if (fetch_enable_q) state_n = SLP_RUN;
      end
      SLP_RUN: begin
        en         = run_en;
        idle_cnt_n = '0;
        if (PULP_CLUSTER != 0) begin
          if (p_elw_start_i && !p_elw_finish_i) state_n = SLP_SLEEP;
        end else if (!any_busy && !wake_from_sleep_i) begin
          if (IDLE_CYCLES == 0) state_n = SLP_SLEEP;
          else                  state_n = SLP_DRAIN;
        end
      end
      SLP_DRAIN: begin
        en = run_en;
        if (any_busy || wake_from_sleep_i) begin
          state_n    = SLP_RUN;
          idle_cnt_n = '0;
        end else if (idle_cnt == CNT_LAST) begin
          state_n    = SLP_SLEEP;
          idle_cnt_n = '0;
        end else if (idle_cnt != '1) begin
          idle_cnt_n = idle_cnt + 1'b1;
        end
      end
      SLP_SLEEP: begin
        if (PULP_CLUSTER != 0) begin
          en         = {NUM_DOMAINS{pulp_clock_en_i}};
          core_sleep = !debug_p_elw_no_sleep_i;
          if (p_elw_finish_i) state_n = SLP_RUN;
        end else begin
          en         = {NUM_DOMAINS{wake_from_sleep_i}};
          core_sleep = !wake_from_sleep_i;
          if (wake_from_sleep_i || any_busy) state_n = SLP_RUN;
        end
      end
      default: state_n = SLP_OFF;
    endcase
  end

  assign gate_en        = en & {NUM_DOMAINS{fetch_enable_q}};
  assign core_sleep_o   = core_sleep;
  assign fetch_enable_o = fetch_enable_q;
  assign sleep_state_o  = state;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_gate
    cv32e40p_clock_gate u_clock_gate (
      .clk_i        (clk_ungated_i),
      .en_i         (gate_en[d]),
      .scan_cg_en_i (scan_cg_en_i),
      .clk_o        (clk_gated_o[d])
    );
  end

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl_mc.sv
// Bench for cv32e40p_sleep_ctrl_mc: a WFI-configured and a cluster-configured instance share stimulus.
module tb_cv32e40p_sleep_ctrl_mc;
  localparam int unsigned ND   = 2;
  localparam int unsigned IDLE = 4;
  localparam logic [ND-1:0] MASK = 2'b10;

  logic clk = 1'b0, rst = 1'b1, scan = 1'b0, fe = 1'b0, wake = 1'b0;
  logic pce = 1'b1, elw_start = 1'b0, elw_finish = 1'b0, dbg = 1'b0;
  logic [ND-1:0] busy = '0;
  logic [ND-1:0] gated, gated_p;
  logic sleep, sleep_p, feo, feo_p;
  logic [1:0] st, st_p;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  cv32e40p_sleep_ctrl_mc #(.NUM_DOMAINS(ND), .IDLE_CYCLES(IDLE), .AUTO_GATE_MASK(MASK), .PULP_CLUSTER(0)) dut (
    .clk_ungated_i(clk), .rst(rst), .scan_cg_en_i(scan), .clk_gated_o(gated), .core_sleep_o(sleep),
    .fetch_enable_i(fe), .fetch_enable_o(feo), .busy_i(busy), .wake_from_sleep_i(wake),
    .pulp_clock_en_i(pce), .p_elw_start_i(elw_start), .p_elw_finish_i(elw_finish),
    .debug_p_elw_no_sleep_i(dbg), .sleep_state_o(st));

  cv32e40p_sleep_ctrl_mc #(.NUM_DOMAINS(ND), .IDLE_CYCLES(IDLE), .AUTO_GATE_MASK(MASK), .PULP_CLUSTER(1)) dut_p (
    .clk_ungated_i(clk), .rst(rst), .scan_cg_en_i(scan), .clk_gated_o(gated_p), .core_sleep_o(sleep_p),
    .fetch_enable_i(fe), .fetch_enable_o(feo_p), .busy_i(busy), .wake_from_sleep_i(wake),
    .pulp_clock_en_i(pce), .p_elw_start_i(elw_start), .p_elw_finish_i(elw_finish),
    .debug_p_elw_no_sleep_i(dbg), .sleep_state_o(st_p));

  // Reference view: m_quiet counts consecutive idle cycles seen while awake; sleep once it exceeds IDLE.
  bit m_fe, m_on, m_sleep;
  int m_quiet;
  logic [ND-1:0] m_busyq;
  bit p_fe, p_on, p_elw;
  logic [ND-1:0] p_busyq;
  logic [ND-1:0] exp_gate, exp_gate_p;

  task automatic model_reset();
    m_fe = 0; m_on = 0; m_sleep = 0; m_quiet = 0; m_busyq = '0;
    p_fe = 0; p_on = 0; p_elw = 0; p_busyq = '0;
  endtask

  function automatic logic [ND-1:0] run_gate(logic [ND-1:0] bq);
    logic [ND-1:0] g;
    for (int d = 0; d < int'(ND); d++) g[d] = !MASK[d] || bq[d] || wake;
    return g;
  endfunction

  function automatic logic [1:0] m_state();
    if (!m_on) return 2'd0;
    if (m_sleep) return 2'd3;
    return (m_quiet > 0) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] p_state();
    if (!p_on) return 2'd0;
    return p_elw ? 2'd3 : 2'd1;
  endfunction

  task automatic tick();
    logic [ND-1:0] g;
    if (!m_on) g = '0; else if (m_sleep) g = {ND{wake}}; else g = run_gate(m_busyq);
    exp_gate = (g & {ND{m_fe}}) | {ND{scan}};
    if (!p_on) g = '0; else if (p_elw) g = {ND{pce}}; else g = run_gate(p_busyq);
    exp_gate_p = (g & {ND{p_fe}}) | {ND{scan}};
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      if (!m_on) m_on = m_fe;
      else if (m_sleep) begin if (wake || (|m_busyq)) m_sleep = 0; end
      else if (wake || (|m_busyq)) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet > int'(IDLE)) begin m_sleep = 1; m_quiet = 0; end
      end
      m_fe = m_fe | fe; m_busyq = busy;
      if (!p_on) p_on = p_fe;
      else if (p_elw) begin if (elw_finish) p_elw = 0; end
      else if (elw_start && !elw_finish) p_elw = 1;
      p_fe = p_fe | fe; p_busyq = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    tick(); tick();
    checks++; if (st !== 2'd0) $display("FAIL reset_state: got %0d want 0", st); else passes++;
    checks++; if (sleep !== 1'b0) $display("FAIL reset_sleep: got %0b want 0", sleep); else passes++;
    checks++; if (feo !== 1'b0) $display("FAIL reset_fe: got %0b want 0", feo); else passes++;
    checks++; if (gated !== 2'b00) $display("FAIL reset_gated: got %b want 00", gated); else passes++;
    checks++; if ({st_p, sleep_p, feo_p, gated_p} !== 6'b0) $display("FAIL reset_pulp: got %b want 000000", {st_p, sleep_p, feo_p, gated_p}); else passes++;
    rst = 0;
  endtask

  task automatic test_fetch_enable();
    tick(); tick();
    checks++; if (st !== 2'd0) $display("FAIL fe_off_state: got %0d want 0", st); else passes++;
    fe = 1; busy = 2'b11;
    tick();
    checks++; if (feo !== 1'b1) $display("FAIL fe_sticky: got %0b want 1", feo); else passes++;
    checks++; if (st !== 2'd0) $display("FAIL fe_state_k: got %0d want 0", st); else passes++;
    fe = 0;
    tick();
    checks++; if (st !== 2'd1 || st_p !== 2'd1) $display("FAIL fe_run: got %0d/%0d want 1/1", st, st_p); else passes++;
    checks++; if (feo !== 1'b1) $display("FAIL fe_hold: got %0b want 1", feo); else passes++;
    tick();
    checks++; if (gated !== 2'b11 || gated_p !== 2'b11) $display("FAIL fe_gated: got %b/%b want 11/11", gated, gated_p); else passes++;
  endtask

  task automatic test_wfi_entry();
    tick(); tick();
    busy = 2'b00;
    tick();
    checks++; if (st !== 2'd1) $display("FAIL wfi_last_run: got %0d want 1", st); else passes++;
    for (int i = 0; i < int'(IDLE); i++) begin
      tick();
      checks++; if (st !== 2'd2) $display("FAIL wfi_drain%0d: got %0d want 2", i, st); else passes++;
      checks++; if (gated !== 2'b01) $display("FAIL wfi_drain_gated%0d: got %b want 01", i, gated); else passes++;
    end
    tick();
    checks++; if (st !== 2'd3 || sleep !== 1'b1) $display("FAIL wfi_sleep: got st=%0d sleep=%0b want 3/1", st, sleep); else passes++;
    tick();
    checks++; if (gated !== 2'b00 || st !== 2'd3) $display("FAIL wfi_stopped: got gated=%b st=%0d want 00/3", gated, st); else passes++;
    wake = 1; #1;
    checks++; if (sleep !== 1'b0) $display("FAIL wfi_wake_comb: got %0b want 0", sleep); else passes++;
    tick();
    checks++; if (gated !== 2'b11 || st !== 2'd1) $display("FAIL wfi_wake: got gated=%b st=%0d want 11/1", gated, st); else passes++;
    wake = 0;
  endtask

  task automatic test_drain_abort();
    tick(); tick(); tick();
    checks++; if (st !== 2'd2) $display("FAIL abort_drain: got %0d want 2", st); else passes++;
    busy = 2'b10;
    tick();
    checks++; if (st !== 2'd2) $display("FAIL abort_lag: got %0d want 2", st); else passes++;
    tick();
    checks++; if (st !== 2'd1) $display("FAIL abort_run: got %0d want 1", st); else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (st !== 2'd1 || gated !== 2'b11) $display("FAIL abort_hold%0d: got st=%0d gated=%b want 1/11", i, st, gated); else passes++;
    end
  endtask

  task automatic test_auto_gate();
    busy = 2'b01;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (gated !== 2'b01 || st !== 2'd1) $display("FAIL auto_gate%0d: got gated=%b st=%0d want 01/1", i, gated, st); else passes++;
      tick();
    end
  endtask

  task automatic test_pulp_elw();
    elw_start = 1; elw_finish = 1;
    tick();
    checks++; if (st_p !== 2'd1) $display("FAIL elw_both: got %0d want 1", st_p); else passes++;
    elw_finish = 0;
    tick();
    checks++; if (st_p !== 2'd3 || sleep_p !== 1'b1) $display("FAIL elw_enter: got st=%0d sleep=%0b want 3/1", st_p, sleep_p); else passes++;
    checks++; if (st !== 2'd1) $display("FAIL elw_ignored: got %0d want 1", st); else passes++;
    elw_start = 0; pce = 0;
    tick();
    checks++; if (gated_p !== 2'b00 || sleep_p !== 1'b1) $display("FAIL elw_stop: got gated=%b sleep=%0b want 00/1", gated_p, sleep_p); else passes++;
    dbg = 1; #1;
    checks++; if (sleep_p !== 1'b0) $display("FAIL elw_dbg: got %0b want 0", sleep_p); else passes++;
    pce = 1;
    tick();
    checks++; if (gated_p !== 2'b11) $display("FAIL elw_pce: got %b want 11", gated_p); else passes++;
    elw_finish = 1;
    tick();
    checks++; if (st_p !== 2'd1) $display("FAIL elw_finish: got %0d want 1", st_p); else passes++;
    elw_finish = 0; dbg = 0;
  endtask

  task automatic test_reset_in_sleep();
    busy = 2'b00;
    for (int i = 0; i < int'(IDLE) + 2; i++) tick();
    checks++; if (st !== 2'd3) $display("FAIL rs_sleep: got %0d want 3", st); else passes++;
    rst = 1; scan = 1; #1; model_reset();
    checks++; if ({st, sleep, feo} !== 4'b0) $display("FAIL rs_outputs: got %b want 0000", {st, sleep, feo}); else passes++;
    checks++; if ({st_p, sleep_p, feo_p} !== 4'b0) $display("FAIL rs_outputs_p: got %b want 0000", {st_p, sleep_p, feo_p}); else passes++;
    tick(); tick();
    checks++; if (gated !== 2'b11 || gated_p !== 2'b11) $display("FAIL rs_scan: got %b/%b want 11/11", gated, gated_p); else passes++;
    scan = 0;
    tick();
    checks++; if (gated !== 2'b00 || gated_p !== 2'b00) $display("FAIL rs_stopped: got %b/%b want 00/00", gated, gated_p); else passes++;
    rst = 0;
  endtask

  task automatic test_random();
    fe = 1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) fe = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) busy = ND'($urandom_range(0, 3));
      wake       = ($urandom_range(0, 15) == 0);
      elw_start  = ($urandom_range(0, 7) == 0);
      elw_finish = ($urandom_range(0, 5) == 0);
      pce        = 1'($urandom_range(0, 1));
      dbg        = ($urandom_range(0, 3) == 0);
      scan       = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      if (rst) begin #1; model_reset(); end
      tick();
      checks++; if (st !== m_state()) $display("FAIL rnd_state c%0d: got %0d want %0d", i, st, m_state()); else passes++;
      checks++; if (sleep !== (m_sleep && !wake)) $display("FAIL rnd_sleep c%0d: got %0b want %0b", i, sleep, m_sleep && !wake); else passes++;
      checks++; if (feo !== m_fe) $display("FAIL rnd_fe c%0d: got %0b want %0b", i, feo, m_fe); else passes++;
      checks++; if (gated !== exp_gate) $display("FAIL rnd_gated c%0d: got %b want %b", i, gated, exp_gate); else passes++;
      checks++; if (st_p !== p_state()) $display("FAIL rnd_state_p c%0d: got %0d want %0d", i, st_p, p_state()); else passes++;
      checks++; if (sleep_p !== (p_elw && !dbg)) $display("FAIL rnd_sleep_p c%0d: got %0b want %0b", i, sleep_p, p_elw && !dbg); else passes++;
      checks++; if (feo_p !== p_fe) $display("FAIL rnd_fe_p c%0d: got %0b want %0b", i, feo_p, p_fe); else passes++;
      checks++; if (gated_p !== exp_gate_p) $display("FAIL rnd_gated_p c%0d: got %b want %b", i, gated_p, exp_gate_p); else passes++;
    end
    rst = 0; scan = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_enable();
    test_wfi_entry();
    test_drain_abort();
    test_auto_gate();
    test_pulp_elw();
    test_reset_in_sleep();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
